// File: rtl/cpu_pkg.sv
// Shared register-file constants and helpers for the writeback path.
package cpu_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t rd);
    return NUM_REGS'(1) << rd;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard for long-latency ops plus decode hazard compare.
module regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic                  wr_valid,
  input  logic [REG_ADDR_W-1:0] wr_reg,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic                  hazard,
  output logic [NUM_REGS-1:0]   pending
);
  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pending_nxt_s;
  logic                rs1_busy_s;
  logic                rs2_busy_s;

  // Clear first, then set, so a reissue to the retiring rd stays pending.
  always_comb begin
    pending_nxt_s = pending_r;
    if (clr_valid) begin
      pending_nxt_s = pending_nxt_s & ~reg_onehot(clr_rd);
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (set_valid && (set_rd != REG_ZERO)) begin
      pending_nxt_s = pending_nxt_s | reg_onehot(set_rd);
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Pending mask register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // The in-flight term covers the cycle between accept and register-file commit.
  assign rs1_busy_s = rs1_used && (rs1 != REG_ZERO) &&
                      (pending_r[rs1] || (wr_valid && (wr_reg == rs1)));
  assign rs2_busy_s = rs2_used && (rs2 != REG_ZERO) &&
                      (pending_r[rs2] || (wr_valid && (wr_reg == rs2)));

  assign hazard  = rs1_busy_s || rs2_busy_s;
  assign pending = pending_r;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (A) and long-latency (B) writeback ports.
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int XLEN         = cpu_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic                  hazard,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [XLEN-1:0]       write_data,
  output logic [NUM_REGS-1:0]   pending
);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]            starve_cnt_r;
  logic                  grant_a_s;
  logic                  grant_b_s;
  logic                  reg_write_r;
  logic [REG_ADDR_W-1:0] write_reg_r;
  logic [XLEN-1:0]       write_data_r;

  // Requests seen during reset are never granted.
  assign grant_b_s = !rst && b_valid && (!a_valid || (starve_cnt_r == STARVE_MAX));
  assign grant_a_s = !rst && a_valid && !grant_b_s;
  assign a_ready   = grant_a_s;
  assign b_ready   = grant_b_s;

  // Starvation counter: counts consecutive cycles B waited, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 4'd0;
    end else if (b_valid && !grant_b_s) begin
      if (starve_cnt_r != STARVE_MAX) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= 4'd0;
    end
  end

  // Registered write port; x0 writes are consumed without a write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_r  <= 1'b0;
      write_reg_r  <= '0;
      write_data_r <= '0;
    end else if (grant_b_s) begin
      reg_write_r  <= (b_rd != REG_ZERO);
      write_reg_r  <= b_rd;
      write_data_r <= b_data;
    end else if (grant_a_s) begin
      reg_write_r  <= (a_rd != REG_ZERO);
      write_reg_r  <= a_rd;
      write_data_r <= a_data;
    end else begin
      reg_write_r  <= 1'b0;
      write_reg_r  <= write_reg_r;
      write_data_r <= write_data_r;
    end
  end

  assign reg_write  = reg_write_r;
  assign write_reg  = write_reg_r;
  assign write_data = write_data_r;

  regfile_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (issue_valid),
    .set_rd    (issue_rd),
    .clr_valid (grant_b_s),
    .clr_rd    (b_rd),
    .wr_valid  (reg_write_r),
    .wr_reg    (write_reg_r),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .hazard    (hazard),
    .pending   (pending)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, starvation, scoreboard and hazard.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, issue_valid, rs1_used, rs2_used;
  logic [4:0]  a_rd, b_rd, issue_rd, rs1, rs2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, hazard, reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pending;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .hazard(hazard), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .pending(pending)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change 1 time unit after the edge, checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    rs1 = 5'd0; rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hAAAA_5555;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
    step(); step();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got=%b exp=0", reg_write); end
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending got=%h exp=0", pending); end
    checks++; if (write_reg !== 5'd0 || write_data !== 32'd0) begin
      errors++; $display("FAIL reset_write_port got=%0d/%h exp=0/0", write_reg, write_data); end
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h0000_1234;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL single_a_ready got=%b%b exp=10", a_ready, b_ready); end
    step();
    idle_inputs();
    checks++; if (reg_write !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'h0000_1234) begin
      errors++; $display("FAIL single_a_write got=%b/%0d/%h exp=1/3/00001234", reg_write, write_reg, write_data); end
    step();
    checks++; if (reg_write !== 1'b0 || write_reg !== 5'd3 || write_data !== 32'h0000_1234) begin
      errors++; $display("FAIL single_a_hold got=%b/%0d/%h exp=0/3/00001234", reg_write, write_reg, write_data); end
  endtask

  task automatic test_starvation();
    a_valid = 1'b1; a_rd = 5'd1;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h0000_BEEF;
    for (int i = 0; i < 4; i++) begin
      a_data = 32'h100 + 32'(i);
      #1;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
        errors++; $display("FAIL starve_a_wins[%0d] got=%b%b exp=10", i, a_ready, b_ready); end
      step();
    end
    #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      errors++; $display("FAIL starve_b_wins got=%b%b exp=01", a_ready, b_ready); end
    step();
    b_valid = 1'b0;
    checks++; if (reg_write !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'h0000_BEEF) begin
      errors++; $display("FAIL starve_b_write got=%b/%0d/%h exp=1/9/0000BEEF", reg_write, write_reg, write_data); end
    // A held its request; with the counter cleared a fresh B request loses again.
    a_data = 32'h0000_0777; b_valid = 1'b1; b_rd = 5'd10;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL starve_cleared got=%b%b exp=10", a_ready, b_ready); end
    step();
    idle_inputs();
    checks++; if (write_reg !== 5'd1 || write_data !== 32'h0000_0777) begin
      errors++; $display("FAIL starve_a_after got=%0d/%h exp=1/00000777", write_reg, write_data); end
    step();
  endtask

  task automatic test_scoreboard_hazard();
    issue_valid = 1'b1; issue_rd = 5'd6;
    step();
    issue_valid = 1'b0; rs1 = 5'd6; rs1_used = 1'b1;
    #1;
    checks++; if (pending[6] !== 1'b1 || hazard !== 1'b1) begin
      errors++; $display("FAIL sb_set got=%b/%b exp=1/1", pending[6], hazard); end
    rs1_used = 1'b0;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_unused got=%b exp=0", hazard); end
    rs1_used = 1'b1;
    step();
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_wait got=%b exp=1", hazard); end
    b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h6666_0006;
    #1;
    checks++; if (b_ready !== 1'b1 || hazard !== 1'b1) begin
      errors++; $display("FAIL sb_accept got=%b/%b exp=1/1", b_ready, hazard); end
    step();
    b_valid = 1'b0;
    #1;
    checks++; if (hazard !== 1'b1 || pending[6] !== 1'b0) begin
      errors++; $display("FAIL sb_inflight got=%b/%b exp=1/0", hazard, pending[6]); end
    step();
    checks++; if (hazard !== 1'b0 || pending[6] !== 1'b0) begin
      errors++; $display("FAIL sb_done got=%b/%b exp=0/0", hazard, pending[6]); end
    idle_inputs();
    // rs2 path; an A write to the same rd must leave the pending bit alone.
    issue_valid = 1'b1; issue_rd = 5'd12;
    step();
    issue_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd12; a_data = 32'h0000_00C0;
    rs2 = 5'd12; rs2_used = 1'b1;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_rs2 got=%b exp=1", hazard); end
    step();
    a_valid = 1'b0;
    step();
    checks++; if (pending !== 32'h0000_1000) begin
      errors++; $display("FAIL sb_a_no_clear got=%h exp=00001000", pending); end
    b_valid = 1'b1; b_rd = 5'd12;
    step();
    idle_inputs();
    step();
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL sb_rs2_clear got=%h exp=0", pending); end
  endtask

  task automatic test_set_wins();
    issue_valid = 1'b1; issue_rd = 5'd6;
    step();
    b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h0000_0066;
    issue_valid = 1'b1; issue_rd = 5'd6;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL setwin_accept got=%b exp=1", b_ready); end
    step();
    idle_inputs();
    checks++; if (pending !== 32'h0000_0040) begin
      errors++; $display("FAIL setwin_pending got=%h exp=00000040", pending); end
    b_valid = 1'b1; b_rd = 5'd6;
    step();
    idle_inputs();
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL setwin_clear got=%h exp=0", pending); end
    step();
  endtask

  task automatic test_x0();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs1 = 5'd0; rs1_used = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1 || hazard !== 1'b0) begin
      errors++; $display("FAIL x0_accept got=%b/%b exp=1/0", a_ready, hazard); end
    step();
    idle_inputs();
    rs1 = 5'd0; rs1_used = 1'b1;
    #1;
    checks++; if (reg_write !== 1'b0 || pending !== 32'd0) begin
      errors++; $display("FAIL x0_no_write got=%b/%h exp=0/0", reg_write, pending); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL x0_hazard got=%b exp=0", hazard); end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_single_a();
    test_starvation();
    test_scoreboard_hazard();
    test_set_wins();
    test_x0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
